// File: rtl/mem_pkg.sv
// Shared encodings for the load and store datapaths: address-source codes,
// load FSM states, and the machine word size.
package mem_pkg;

    localparam int unsigned WORD_BYTES = 2;

    typedef enum logic [2:0] {
        SRC_PC      = 3'b000,
        SRC_IMM     = 3'b001,
        SRC_MARY    = 3'b010,
        SRC_SHELLEY = 3'b011,
        SRC_SP2     = 3'b100,
        SRC_SPIMM   = 3'b101
    } mem_src_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } load_state_e;

    function automatic logic word_aligned(input logic [15:0] addr);
        return addr[0] == 1'b0;
    endfunction

endpackage

// File: rtl/load_addr_mux.sv
// Effective-address select/add shared by the load and store paths.
// o_legal is low for an unused source code or an odd (misaligned) word address.
module load_addr_mux
    import mem_pkg::*;
(
    input  logic [2:0]  i_src,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_sp,
    input  logic [15:0] i_ze_imm,
    input  logic [15:0] i_ls_imm,
    input  logic [15:0] i_mary,
    input  logic [15:0] i_shelley,
    output logic [15:0] o_addr,
    output logic        o_legal
);

    logic w_src_ok;

    always_comb begin
        o_addr   = '0;
        w_src_ok = 1'b1;
        case (i_src)
            SRC_PC:      o_addr = i_pc;
            SRC_IMM:     o_addr = i_ze_imm;
            SRC_MARY:    o_addr = i_mary;
            SRC_SHELLEY: o_addr = i_shelley;
            SRC_SP2:     o_addr = i_sp + 16'(WORD_BYTES);
            SRC_SPIMM:   o_addr = i_sp + i_ls_imm;
            default:     w_src_ok = 1'b0;
        endcase
    end

    assign o_legal = w_src_ok & word_aligned(o_addr);

endmodule

// File: rtl/mem_load_unit.sv
// Multi-cycle load unit: latches an effective address, issues one read strobe,
// waits READ_LAT cycles, captures the returned word and pulses done.
module mem_load_unit
    import mem_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  LoadSrc,
    input  logic [15:0] pc,
    input  logic [15:0] sp_in,
    input  logic [15:0] ze_imm,
    input  logic [15:0] ls_imm,
    input  logic [15:0] MaryData,
    input  logic [15:0] ShelleyData,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] load_data,
    output logic [15:0] sp_out,
    output logic        sp_we
);

    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    load_state_e r_state;
    logic [1:0]  r_cnt;
    logic [2:0]  r_src;
    logic [15:0] r_sp;
    logic [15:0] w_addr;
    logic        w_legal;

    load_addr_mux u_addr_mux (
        .i_src     (LoadSrc),
        .i_pc      (pc),
        .i_sp      (sp_in),
        .i_ze_imm  (ze_imm),
        .i_ls_imm  (ls_imm),
        .i_mary    (MaryData),
        .i_shelley (ShelleyData),
        .o_addr    (w_addr),
        .o_legal   (w_legal)
    );

    // mem_addr doubles as the latched address register, so it holds between loads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_src     <= '0;
            r_sp      <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= '0;
            sp_out    <= '0;
            sp_we     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr <= w_addr;
                        r_src    <= LoadSrc;
                        r_sp     <= sp_in + 16'(WORD_BYTES);
                        busy     <= 1'b1;
                        if (w_legal) begin
                            mem_rd  <= 1'b1;
                            r_state <= ST_REQ;
                        end else begin
                            done    <= 1'b1;
                            err     <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    mem_rd  <= 1'b0;
                    r_cnt   <= CNT_INIT;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else begin
                        load_data <= mem_rdata;
                        done      <= 1'b1;
                        if (r_src == SRC_SP2) begin
                            sp_we  <= 1'b1;
                            sp_out <= r_sp;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    sp_we   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit: three instances (READ_LAT 1, 3, 2) against a
// cycle-level model of the load timing rules plus directed literal checks.
module tb_mem_load_unit;

    localparam int N = 3;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 2;
    endfunction

    logic        clock = 1'b0;
    logic        reset [N];
    logic        start [N];
    logic [2:0]  LoadSrc [N];
    logic [15:0] pc [N], sp_in [N], ze_imm [N], ls_imm [N], MaryData [N], ShelleyData [N];
    logic [15:0] mem_rdata [N];
    logic [15:0] mem_addr [N], load_data [N], sp_out [N];
    logic        mem_rd [N], busy [N], done [N], err [N], sp_we [N];

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        mem_load_unit #(.READ_LAT(L)) u_dut (
            .clock       (clock),
            .reset       (reset[g]),
            .start       (start[g]),
            .LoadSrc     (LoadSrc[g]),
            .pc          (pc[g]),
            .sp_in       (sp_in[g]),
            .ze_imm      (ze_imm[g]),
            .ls_imm      (ls_imm[g]),
            .MaryData    (MaryData[g]),
            .ShelleyData (ShelleyData[g]),
            .mem_rdata   (mem_rdata[g]),
            .mem_addr    (mem_addr[g]),
            .mem_rd      (mem_rd[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .err         (err[g]),
            .load_data   (load_data[g]),
            .sp_out      (sp_out[g]),
            .sp_we       (sp_we[g])
        );
    end

    // Synchronous-read memory: data valid only READ_LAT cycles after the strobe.
    logic [15:0] memory [65536];
    logic        pv [N][4];
    logic [15:0] pa [N][4];

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (reset[i]) begin
                for (int k = 0; k < 4; k++) pv[i][k] <= 1'b0;
            end else begin
                pv[i][0] <= mem_rd[i];
                pa[i][0] <= mem_addr[i];
                for (int k = 1; k < 4; k++) begin
                    pv[i][k] <= pv[i][k-1];
                    pa[i][k] <= pa[i][k-1];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            mem_rdata[i] = (pv[i][lat(i)-1] === 1'b1) ? memory[pa[i][lat(i)-1]] : 16'hA5A5;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    // Model: per instance, the cycle numbers at which each event must occur.
    int          m_start [N], m_rd [N], m_done [N];
    bit          m_err [N], m_pop [N];
    logic [15:0] m_addr [N], m_sp [N], m_ld [N], m_ldn [N];

    function automatic void model_addr(input int i, output logic [15:0] a, output bit ok);
        ok = 1'b1;
        a  = 16'h0000;
        case (LoadSrc[i])
            3'd0: a = pc[i];
            3'd1: a = ze_imm[i];
            3'd2: a = MaryData[i];
            3'd3: a = ShelleyData[i];
            3'd4: a = sp_in[i] + 16'd2;
            3'd5: a = sp_in[i] + ls_imm[i];
            default: ok = 1'b0;
        endcase
        if (a[0]) ok = 1'b0;
    endfunction

    always @(posedge clock) begin : model
        int s;
        logic [15:0] a;
        bit ok;
        s = cyc;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (reset[i]) begin
                m_start[i] = -10; m_rd[i] = -10; m_done[i] = -10;
                m_err[i] = 1'b0; m_pop[i] = 1'b0; m_ld[i] = 16'h0000;
            end else begin
                if (start[i] && s > m_done[i]) begin
                    model_addr(i, a, ok);
                    m_start[i] = s;
                    if (ok) begin
                        m_rd[i]   = s + 1;
                        m_done[i] = s + 2 + lat(i);
                        m_err[i]  = 1'b0;
                        m_pop[i]  = (LoadSrc[i] == 3'd4);
                        m_addr[i] = a;
                        m_sp[i]   = sp_in[i] + 16'd2;
                        m_ldn[i]  = memory[a];
                    end else begin
                        m_rd[i]   = -10;
                        m_done[i] = s + 1;
                        m_err[i]  = 1'b1;
                        m_pop[i]  = 1'b0;
                    end
                end
                if (cyc == m_done[i] && !m_err[i]) m_ld[i] = m_ldn[i];
            end
        end
    end

    int          rd_cnt [N], done_cnt [N];
    logic [15:0] last_rd_addr [N];

    always @(negedge clock) begin : compare
        bit e_rd, e_done, e_err, e_busy, e_we;
        logic [15:0] e_ld;
        for (int i = 0; i < N; i++) begin
            if (mem_rd[i] === 1'b1) begin
                rd_cnt[i]++;
                last_rd_addr[i] = mem_addr[i];
            end
            if (done[i] === 1'b1) done_cnt[i]++;
            if (reset[i]) begin
                e_rd = 0; e_done = 0; e_err = 0; e_busy = 0; e_we = 0; e_ld = 16'h0000;
                chk("rst_mem_addr", i, mem_addr[i], 16'h0000);
                chk("rst_sp_out", i, sp_out[i], 16'h0000);
            end else begin
                e_rd   = (cyc == m_rd[i]);
                e_done = (cyc == m_done[i]);
                e_err  = e_done && m_err[i];
                e_busy = (cyc > m_start[i]) && (cyc <= m_done[i]);
                e_we   = e_done && m_pop[i] && !m_err[i];
                e_ld   = m_ld[i];
                if (e_rd) chk("mem_addr", i, mem_addr[i], m_addr[i]);
                if (e_we) chk("sp_out", i, sp_out[i], m_sp[i]);
            end
            chk("mem_rd", i, 16'(mem_rd[i]), 16'(e_rd));
            chk("done", i, 16'(done[i]), 16'(e_done));
            chk("err", i, 16'(err[i]), 16'(e_err));
            chk("busy", i, 16'(busy[i]), 16'(e_busy));
            chk("sp_we", i, 16'(sp_we[i]), 16'(e_we));
            chk("load_data", i, load_data[i], e_ld);
        end
    end

    // Decoy values on unselected operands so a wrong mux leg shows up.
    task automatic issue(input int i, input logic [2:0] src, input logic [15:0] val,
                         input logic [15:0] spv, input logic [15:0] lsv,
                         input int extra, output int s);
        @(negedge clock); #2;
        pc[i] = 16'h1000; ze_imm[i] = 16'h2000; MaryData[i] = 16'h3000; ShelleyData[i] = 16'h4000;
        case (src)
            3'd0: pc[i] = val;
            3'd1: ze_imm[i] = val;
            3'd2: MaryData[i] = val;
            3'd3: ShelleyData[i] = val;
            default: ;
        endcase
        sp_in[i] = spv;
        ls_imm[i] = lsv;
        LoadSrc[i] = src;
        start[i] = 1'b1;
        s = cyc;
        repeat (1 + extra) begin
            @(negedge clock); #2;
        end
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int s, input int exp_n);
        int n;
        n = -1;
        for (int k = 0; k < 20; k++) begin
            if (done[i] === 1'b1) begin
                n = cyc - s;
                break;
            end
            @(posedge clock); #1;
        end
        chk("done_latency", i, 16'(n), 16'(exp_n));
    endtask

    initial begin
        int s, rc0, dc0;
        for (int a = 0; a < 65536; a++) memory[a] = 16'(a) ^ 16'h5A5A;
        memory[16'h0040] = 16'hBEEF;
        memory[16'h0000] = 16'h1234;
        memory[16'h0108] = 16'hCAFE;
        memory[16'h0200] = 16'h7777;
        for (int i = 0; i < N; i++) begin
            reset[i] = 1'b1; start[i] = 1'b0; LoadSrc[i] = 3'd0;
            pc[i] = '0; sp_in[i] = '0; ze_imm[i] = '0; ls_imm[i] = '0;
            MaryData[i] = '0; ShelleyData[i] = '0;
            rd_cnt[i] = 0; done_cnt[i] = 0; last_rd_addr[i] = '0;
            m_start[i] = -10; m_rd[i] = -10; m_done[i] = -10;
            m_err[i] = 1'b0; m_pop[i] = 1'b0; m_ld[i] = '0; m_ldn[i] = '0;
            m_addr[i] = '0; m_sp[i] = '0;
        end
        repeat (3) @(negedge clock);
        #2;
        for (int i = 0; i < N; i++) reset[i] = 1'b0;

        // MaryData load, latency 1
        issue(0, 3'd2, 16'h0040, 16'h5000, 16'h0006, 0, s);
        wait_done(0, s, 3);
        chk("t1_load_data", 0, load_data[0], 16'hBEEF);
        chk("t1_err", 0, 16'(err[0]), 16'h0000);
        chk("t1_sp_we", 0, 16'(sp_we[0]), 16'h0000);
        chk("t1_rd_addr", 0, last_rd_addr[0], 16'h0040);

        // pop with wrapping stack pointer, latency 3
        issue(1, 3'd4, 16'h0000, 16'hFFFE, 16'h0006, 0, s);
        wait_done(1, s, 5);
        chk("t2_load_data", 1, load_data[1], 16'h1234);
        chk("t2_sp_we", 1, 16'(sp_we[1]), 16'h0001);
        chk("t2_sp_out", 1, sp_out[1], 16'h0000);
        chk("t2_rd_addr", 1, last_rd_addr[1], 16'h0000);

        // illegal source, then misaligned address
        rc0 = rd_cnt[0];
        issue(0, 3'd7, 16'h0000, 16'h5000, 16'h0006, 0, s);
        wait_done(0, s, 1);
        chk("t3a_err", 0, 16'(err[0]), 16'h0001);
        chk("t3a_load_data", 0, load_data[0], 16'hBEEF);
        issue(0, 3'd3, 16'h0013, 16'h5000, 16'h0006, 0, s);
        wait_done(0, s, 1);
        chk("t3b_err", 0, 16'(err[0]), 16'h0001);
        chk("t3b_load_data", 0, load_data[0], 16'hBEEF);
        @(negedge clock);
        chk("t3_no_rd", 0, 16'(rd_cnt[0] - rc0), 16'h0000);

        // zero-extended immediate source
        issue(0, 3'd1, 16'h0108, 16'h5000, 16'h0006, 0, s);
        wait_done(0, s, 3);
        chk("t3c_load_data", 0, load_data[0], 16'hCAFE);

        // sp+imm, with start held while busy
        rc0 = rd_cnt[1];
        dc0 = done_cnt[1];
        issue(1, 3'd5, 16'h0000, 16'h0100, 16'h0008, 3, s);
        wait_done(1, s, 5);
        chk("t4_load_data", 1, load_data[1], 16'hCAFE);
        chk("t4_sp_we", 1, 16'(sp_we[1]), 16'h0000);
        repeat (4) @(negedge clock);
        chk("t4_rd_addr", 1, last_rd_addr[1], 16'h0108);
        chk("t4_rd_count", 1, 16'(rd_cnt[1] - rc0), 16'h0001);
        chk("t4_done_count", 1, 16'(done_cnt[1] - dc0), 16'h0001);

        // reset during WAIT, latency 2
        issue(2, 3'd2, 16'h0040, 16'h5000, 16'h0006, 0, s);
        wait_done(2, s, 4);
        chk("t5a_load_data", 2, load_data[2], 16'hBEEF);
        issue(2, 3'd0, 16'h0200, 16'h5000, 16'h0006, 0, s);
        @(posedge clock); #3;
        reset[2] = 1'b1;
        #1;
        chk("t5_rst_busy", 2, 16'(busy[2]), 16'h0000);
        chk("t5_rst_mem_rd", 2, 16'(mem_rd[2]), 16'h0000);
        chk("t5_rst_done", 2, 16'(done[2]), 16'h0000);
        chk("t5_rst_err", 2, 16'(err[2]), 16'h0000);
        chk("t5_rst_sp_we", 2, 16'(sp_we[2]), 16'h0000);
        chk("t5_rst_mem_addr", 2, mem_addr[2], 16'h0000);
        chk("t5_rst_load_data", 2, load_data[2], 16'h0000);
        chk("t5_rst_sp_out", 2, sp_out[2], 16'h0000);
        dc0 = done_cnt[2];
        repeat (2) @(negedge clock);
        #2;
        reset[2] = 1'b0;
        repeat (5) @(negedge clock);
        chk("t5_no_done", 2, 16'(done_cnt[2] - dc0), 16'h0000);
        issue(2, 3'd0, 16'h0200, 16'h5000, 16'h0006, 0, s);
        wait_done(2, s, 4);
        chk("t5b_load_data", 2, load_data[2], 16'h7777);

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
